// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: decodes F-extension register usage, gates issue on RAW/WAW
// hazards and duplicate ids, and shadows the fixed-latency FPU to drive writeback.
module fpu_issue_ctrl #(
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned PIPELINE_STAGES = 4,
    parameter int unsigned X_ID_WIDTH      = 4,
    localparam int unsigned CNT_W          = $clog2(PIPELINE_STAGES + 1)
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [31:0]           iss_instr,
    input  logic [X_ID_WIDTH-1:0] iss_id,
    output logic                  iss_accept,
    output logic                  fpu_enable,
    output logic [31:0]           fpu_instr,
    output logic [X_ID_WIDTH-1:0] fpu_id,
    input  logic                  fpu_stall,
    input  logic                  flush,
    output logic                  wb_valid,
    output logic [X_ID_WIDTH-1:0] wb_id,
    output logic [4:0]            wb_rd,
    output logic                  wb_fp,
    output logic                  busy,
    output logic [CNT_W-1:0]      inflight_cnt
);

    localparam int unsigned LAST = PIPELINE_STAGES - 1;

    typedef enum logic [6:0] {
        OPC_LOAD_FP  = 7'b0000111,
        OPC_STORE_FP = 7'b0100111,
        OPC_MADD     = 7'b1000011,
        OPC_MSUB     = 7'b1000111,
        OPC_NMSUB    = 7'b1001011,
        OPC_NMADD    = 7'b1001111,
        OPC_OP_FP    = 7'b1010011
    } opcode_e;

    localparam logic [4:0] F5_FSQRT    = 5'b01011;
    localparam logic [4:0] F5_FCMP     = 5'b10100;
    localparam logic [4:0] F5_FCVT_W_S = 5'b11000;
    localparam logic [4:0] F5_FCVT_S_W = 5'b11010;
    localparam logic [4:0] F5_FMV_X_W  = 5'b11100;
    localparam logic [4:0] F5_FMV_W_X  = 5'b11110;

    typedef struct packed {
        logic                  valid;
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  fp;
    } slot_t;

    opcode_e             opcode;
    logic [4:0]          funct5;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rs3;
    logic [4:0]          rd;
    logic                legal;
    logic                use_rs1;
    logic                use_rs2;
    logic                use_rs3;
    logic                fp_dst;
    logic                has_dst;
    logic [NUM_REGS-1:0] src_mask;
    logic [NUM_REGS-1:0] dst_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] scoreboard;
    logic                id_hit;
    logic                hazard;
    logic                issue;
    logic                retire;
    slot_t               slots [PIPELINE_STAGES];

    assign opcode = opcode_e'(iss_instr[6:0]);
    assign funct5 = iss_instr[31:27];
    assign rs1    = iss_instr[19:15];
    assign rs2    = iss_instr[24:20];
    assign rs3    = iss_instr[31:27];
    assign rd     = iss_instr[11:7];

    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rs3 = 1'b0;
        fp_dst  = 1'b0;
        has_dst = 1'b0;
        case (opcode)
            OPC_OP_FP: begin
                legal   = 1'b1;
                has_dst = 1'b1;
                use_rs1 = !(funct5 inside {F5_FCVT_S_W, F5_FMV_W_X});
                use_rs2 = !(funct5 inside {F5_FSQRT, F5_FCVT_W_S, F5_FCVT_S_W,
                                           F5_FMV_X_W, F5_FMV_W_X});
                fp_dst  = !(funct5 inside {F5_FCMP, F5_FCVT_W_S, F5_FMV_X_W});
            end
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                legal   = 1'b1;
                has_dst = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rs3 = 1'b1;
                fp_dst  = 1'b1;
            end
            OPC_LOAD_FP: begin
                legal   = 1'b1;
                has_dst = 1'b1;
                fp_dst  = 1'b1;
            end
            OPC_STORE_FP: begin
                legal   = 1'b1;
                use_rs2 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Expand register usage to one-hot masks so hazard checks are a single AND.
    always_comb begin
        src_mask = '0;
        dst_mask = '0;
        clr_mask = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if ((use_rs1 && rs1 == 5'(r)) || (use_rs2 && rs2 == 5'(r)) ||
                (use_rs3 && rs3 == 5'(r)))
                src_mask[r] = 1'b1;
            if (fp_dst && rd == 5'(r))
                dst_mask[r] = 1'b1;
            if (retire && slots[LAST].fp && slots[LAST].rd == 5'(r))
                clr_mask[r] = 1'b1;
        end
    end

    always_comb begin
        id_hit = 1'b0;
        for (int unsigned s = 0; s < PIPELINE_STAGES; s++) begin
            if (slots[s].valid && slots[s].id == iss_id)
                id_hit = 1'b1;
        end
    end

    // Scoreboard bits clear only after the wb edge, so a retiring register still blocks.
    assign hazard     = id_hit || |((src_mask | dst_mask) & scoreboard);
    assign iss_ready  = !rst && !fpu_stall && !flush && (!legal || !hazard);
    assign issue      = iss_valid && iss_ready && legal;
    assign iss_accept = issue;
    assign fpu_enable = issue;
    assign fpu_instr  = iss_instr;
    assign fpu_id     = iss_id;
    assign retire     = slots[LAST].valid && !rst && !fpu_stall && !flush;

    always_ff @(posedge ck) begin
        if (rst || flush) begin
            for (int unsigned s = 0; s < PIPELINE_STAGES; s++)
                slots[s] <= '0;
            scoreboard   <= '0;
            inflight_cnt <= '0;
        end else if (!fpu_stall) begin
            if (issue)
                slots[0] <= '{valid: 1'b1, id: iss_id,
                              rd: (has_dst ? rd : 5'd0), fp: fp_dst};
            else
                slots[0] <= '0;
            for (int unsigned s = 1; s < PIPELINE_STAGES; s++)
                slots[s] <= slots[s-1];
            scoreboard   <= (scoreboard & ~clr_mask) | (issue ? dst_mask : '0);
            inflight_cnt <= inflight_cnt + CNT_W'(issue) - CNT_W'(retire);
        end
    end

    assign wb_valid = retire;
    assign wb_id    = slots[LAST].id;
    assign wb_rd    = slots[LAST].rd;
    assign wb_fp    = slots[LAST].fp;
    assign busy     = (inflight_cnt != '0);

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue controller and scoreboard that sits between the core's CORE-V-XIF style issue port and the pipelined FPU model. It decodes register usage of each F-extension instruction and blocks issue on RAW/WAW hazards against in-flight results or on a duplicate instruction id. It tracks every instruction through a fixed-latency shadow pipeline and emits a writeback notification per instruction, honouring FPU stall and flush.

## Interface
- NUM_REGS, 32, FP register count; scoreboard width.
- PIPELINE_STAGES, 4, FPU latency in cycles; must be ≥1.
- X_ID_WIDTH, 4, instruction id width.
- ck  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- iss_valid  in  1  core offers an instruction.
- iss_ready  out  1  controller can take it this cycle.
- iss_instr  in  32  RV32F instruction word.
- iss_id  in  X_ID_WIDTH  instruction id.
- iss_accept  out  1  meaningful when iss_valid&&iss_ready: 1 = legal FP op issued, 0 = rejected.
- fpu_enable  out  1  FPU samples fpu_instr/fpu_id at this edge.
- fpu_instr  out  32  instruction to FPU.
- fpu_id  out  X_ID_WIDTH  id to FPU.
- fpu_stall  in  1  FPU pipeline full; freezes tracking.
- flush  in  1  kill all in-flight instructions.
- wb_valid  out  1  instruction completes this cycle.
- wb_id  out  X_ID_WIDTH  id of completing instruction.
- wb_rd  out  5  destination register index.
- wb_fp  out  1  1 = destination is FP RF, 0 = integer/none.
- busy  out  1  any slot valid.
- inflight_cnt  out  $clog2(PIPELINE_STAGES+1)  valid slot count.

## Operation
- Decode (combinational, opcode = instr[6:0]): OP-FP 1010011 reads rs1,rs2, writes fd; FMADD/FMSUB/FNMSUB/FNMADD (1000011/1000111/1001011/1001111) read rs1,rs2,rs3=instr[31:27], write fd; FLW 0000111 writes fd, no FP source; FSW 0100111 reads rs2 only, no FP dest. Others illegal.
- OP-FP funct5=instr[31:27]: 10100 (compare), 11000 (FCVT.W), 11100 (FMV.X/FCLASS) → integer dest (wb_fp=0); 11010 (FCVT.S.W), 11110 (FMV.W.X) → rs1 not an FP source; all single-source ops (FSQRT, conversions) ignore rs2.
- Scoreboard: NUM_REGS bits; set on issue of an FP-dest instruction, cleared when that instruction reaches wb. No bypass: a bit being cleared this cycle still blocks.
- hazard = any used FP source or FP dest has scoreboard bit set, or iss_id equals id of any valid slot.
- iss_ready = !rst && !fpu_stall && !flush && (illegal || !hazard). Illegal instructions accepted with iss_accept=0, never reach FPU or wb.
- fpu_enable = iss_valid && iss_ready && legal; fpu_instr/fpu_id pass iss_instr/iss_id through.
- Shadow pipeline: PIPELINE_STAGES slots {valid,id,rd,wb_fp}. Issue loads slot 0; each non-stalled edge shifts; slot PIPELINE_STAGES-1 drives wb_* registered outputs.
- fpu_stall=1: slots, scoreboard and counters hold; wb_valid=0.
- flush=1: next edge clears all slots and scoreboard; wb_valid=0; no issue that cycle. flush overrides fpu_stall.
- rst: same clearing as flush.

## Timing
- Reset values: iss_ready=0, iss_accept=0, fpu_enable=0, wb_valid=0, wb_id=0, wb_rd=0, wb_fp=0, busy=0, inflight_cnt=0, scoreboard=0.
- Handshake in cycle 0 → wb_valid high for exactly one cycle in cycle PIPELINE_STAGES, plus one per stall cycle in between.
- Throughput one instruction/cycle with no hazards.
- Dependent instruction on rd of instruction issued in cycle 0 gets iss_ready in cycle PIPELINE_STAGES+1 earliest.
- Issue and wb in same cycle: inflight_cnt unchanged; scoreboard set and clear on different regs both take effect.
- inflight_cnt never exceeds PIPELINE_STAGES.

## Test plan
- FADD.S f3,f1,f2 (0x002081D3) id=1 at cycle 0 → fpu_enable=1 cycle 0; wb_valid=1, wb_id=1, wb_rd=3, wb_fp=1 in cycle 4; busy/inflight_cnt 1 in cycles 1–4.
- FADD.S above then FMUL.S f4,f3,f5 (0x10518253) id=2 held valid → iss_ready=0 cycles 1–4, issues cycle 5, wb cycle 9.
- Four independent FADDs ids 1–4 back-to-back, then id=2 offered in cycle 4 → first four issue cycles 0–3; duplicate id=2 blocked until cycle 6 (after its wb in cycle 5).
- FADD id=1 cycle 0, fpu_stall=1 cycles 2–3 → wb in cycle 6; iss_ready=0 during stall.
- Three in flight, flush in cycle 2 → no wb_valid afterwards; inflight_cnt=0, busy=0 cycle 3; FMUL reading f3 issues cycle 3.
- Illegal word 0x00000013 → iss_ready=1, iss_accept=0, fpu_enable=0, no wb; FEQ.S id=7 → wb_fp=0 in cycle 4, scoreboard unchanged.
